pbus_initiator: RTL

Wishbone initiator that turns single-byte core load/store requests into 8-bit Wishbone cycles on the 4 KB on-chip peripheral window at 0xC00000–0xC00FFF. This window covers IO, config registers, SYSCALL and scratchpad. The block sits between the KC-LS1u core data port and the peripheral bus responder. In synchronous mode it completes each cycle on the responder's ACK. In asynchronous mode it completes after a programmed wait count, which serves slow external IO bridges.

---
 rtl/pbus_initiator.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pbus_initiator.sv
// Byte-wide Wishbone initiator for the 4 KB peripheral window at 0xC00000-0xC00FFF.
// Optional macro PBUS_TIMEOUT_EN aborts sync-mode cycles that never see ACK.
module pbus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SYNC_MODE,
  input  logic [6:0]  ASYNC_WAITCYCLE,
  input  logic        CPU_REQ,
  input  logic [23:0] CPU_ADR,
  input  logic        CPU_WE,
  input  logic [7:0]  CPU_WDAT,
  output logic [7:0]  CPU_RDAT,
  output logic        CPU_RDY,
  output logic        CPU_ERR,
  output logic        CPU_WAIT,
  output logic [11:0] WB_ADRo,
  output logic [7:0]  WB_DATo,
  input  logic [7:0]  WB_DATi,
  output logic        WB_WEo,
  output logic        WB_CYCo,
  output logic        WB_STBo,
  input  logic        WB_ACKi
);

  localparam int unsigned OFS_W  = 12;
  localparam int unsigned DAT_W  = 8;
  localparam int unsigned WAIT_W = 7;
  localparam logic [11:0] WIN_BASE = 12'hC00;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
  logic [OFS_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   wdat_q, wdat_d;
  logic               we_q, we_d;
  logic [DAT_W-1:0]   rdat_q, rdat_d;
  logic               rdy_q, rdy_d;
  logic               err_q, err_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               wait_q, wait_d;
  logic               done_c;

`ifdef PBUS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
`else
  logic               unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Completion condition: ACK in sync mode, expired wait count in async mode
  assign done_c = mode_q ? WB_ACKi : (wcnt_q == '0);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      wcnt_q  <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      wait_q  <= 1'b0;
`ifdef PBUS_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wcnt_q  <= wcnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      wait_q  <= wait_d;
`ifdef PBUS_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wcnt_d  = wcnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    wait_d  = wait_q;
`ifdef PBUS_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (CPU_REQ) begin
          if (CPU_ADR[23:12] == WIN_BASE) begin
            adr_d   = CPU_ADR[11:0];
            we_d    = CPU_WE;
            wdat_d  = CPU_WDAT;
            mode_d  = SYNC_MODE;
            wcnt_d  = ASYNC_WAITCYCLE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            wait_d  = 1'b1;
            state_d = BUS;
`ifdef PBUS_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      BUS: begin
        if (done_c) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          wait_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
          if (!we_q) rdat_d = WB_DATi;
        end else if (!mode_q) begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
`ifdef PBUS_TIMEOUT_EN
        else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Responder never answered: abort and report a bus error
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          wait_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
          if (!we_q) rdat_d = 8'hFF;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  assign CPU_RDAT = rdat_q;
  assign CPU_RDY  = rdy_q;
  assign CPU_ERR  = err_q;
  assign CPU_WAIT = wait_q;
  assign WB_ADRo  = adr_q;
  assign WB_DATo  = wdat_q;
  assign WB_WEo   = we_q;
  assign WB_CYCo  = cyc_q;
  assign WB_STBo  = stb_q;

endmodule
